// File: rtl/t_seq_pkg.sv
// Shared types and constants for the T-frame sequencer.
package t_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      DRAIN,
      DONE
   } seq_state_t;

   // Number of T result streams (nu = 0, 1, 2).
   localparam int NU_VALUES             = 3;
   localparam int DRAIN_TIMEOUT_DEFAULT = 8;

endpackage

// File: rtl/t_frame_sequencer_bank_tracker.sv
// Ping-pong result bank bookkeeping: per-bank full flags and the bank being written.
module t_bank_tracker (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       i_set,
   input  logic [1:0] i_release,
   output logic [1:0] o_bank_full,
   output logic       o_wr_bank
);

   logic [1:0] r_bank_full;
   logic       r_wr_bank;

   // Set the write bank on completion (set beats a same-cycle release), then flip banks.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_bank_full <= '0;
         r_wr_bank   <= 1'b0;
      end else begin
         for (int unsigned b = 0; b < 2; b++) begin
            if (i_set && (r_wr_bank == 1'(b))) begin
               r_bank_full[b] <= 1'b1;
            end else if (i_release[b]) begin
               r_bank_full[b] <= 1'b0;
            end
         end
         if (i_set) begin
            r_wr_bank <= ~r_wr_bank;
         end
      end
   end

   assign o_bank_full = r_bank_full;
   assign o_wr_bank   = r_wr_bank;

endmodule

// File: rtl/t_frame_sequencer.sv
// Sequences one FFT frame through T and forwards T results into a ping-pong result BRAM.
module t_frame_sequencer
   import t_seq_pkg::*;
#(
   parameter  int BIT_WIDTH     = 32,
   parameter  int I             = 160,
   parameter  int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEFAULT,
   localparam int ADDR_W        = $clog2(I)
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 frame_ready,
   output logic                 frame_ack,
   output logic [ADDR_W-1:0]    bin_addr,
   input  logic [BIT_WIDTH-1:0] bin_data,
   output logic                 t_fft_valid,
   output logic [BIT_WIDTH-1:0] t_fft_data,
   input  logic                 t_output_valid,
   input  logic [ADDR_W-1:0]    t_output_address,
   input  logic [BIT_WIDTH-1:0] t_out_0,
   input  logic [BIT_WIDTH-1:0] t_out_1,
   input  logic [BIT_WIDTH-1:0] t_out_2,
   output logic                 res_we,
   output logic [ADDR_W:0]      res_addr,
   output logic [BIT_WIDTH-1:0] res_data_0,
   output logic [BIT_WIDTH-1:0] res_data_1,
   output logic [BIT_WIDTH-1:0] res_data_2,
   output logic [1:0]           bank_full,
   input  logic [1:0]           bank_release,
   output logic                 result_ready,
   output logic                 result_bank,
   output logic                 err_timeout
);

   localparam int DCNT_W = $clog2(DRAIN_TIMEOUT + 1);

   seq_state_t          r_state;
   logic [ADDR_W-1:0]   r_bin_addr;
   logic                r_issue;
   logic                r_fft_valid;
   logic                r_frame_ack;
   logic [DCNT_W-1:0]   r_drain_cnt;
   logic                r_err_timeout;
   logic                r_result_ready;
   logic                r_result_bank;
   logic                r_res_we;
   logic [ADDR_W:0]     r_res_addr;
   logic [BIT_WIDTH-1:0] r_res_data [NU_VALUES];

   logic                w_bank_set;
   logic                w_wr_bank;
   logic [1:0]          w_bank_full;
   logic                w_fwd_active;
   logic [BIT_WIDTH-1:0] w_t_out [NU_VALUES];

   assign w_t_out[0]   = t_out_0;
   assign w_t_out[1]   = t_out_1;
   assign w_t_out[2]   = t_out_2;
   assign w_bank_set   = (r_state == DONE);
   assign w_fwd_active = (r_state == FEED) || (r_state == DRAIN);

   t_bank_tracker u_bank_tracker (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .i_set       (w_bank_set),
      .i_release   (bank_release),
      .o_bank_full (w_bank_full),
      .o_wr_bank   (w_wr_bank)
   );

   // Frame FSM: address issue, drain watchdog and completion handshake, all outputs registered.
   // t_fft_valid is the issue flag delayed one cycle to line up with the 1-cycle BRAM read;
   // frame_ack is armed one address early so it is high while bin_addr shows I-1.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state        <= IDLE;
         r_bin_addr     <= '0;
         r_issue        <= 1'b0;
         r_fft_valid    <= 1'b0;
         r_frame_ack    <= 1'b0;
         r_drain_cnt    <= '0;
         r_err_timeout  <= 1'b0;
         r_result_ready <= 1'b0;
         r_result_bank  <= 1'b0;
      end else begin
         r_fft_valid    <= r_issue;
         r_frame_ack    <= 1'b0;
         r_result_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (frame_ready && !w_bank_full[w_wr_bank]) begin
                  r_state    <= FEED;
                  r_bin_addr <= '0;
                  r_issue    <= 1'b1;
               end
            end
            FEED: begin
               if (r_bin_addr == ADDR_W'(I - 1)) begin
                  r_state     <= DRAIN;
                  r_issue     <= 1'b0;
                  r_drain_cnt <= '0;
               end else begin
                  r_bin_addr <= r_bin_addr + 1'b1;
                  if (r_bin_addr == ADDR_W'(I - 2)) begin
                     r_frame_ack <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (t_output_valid && (t_output_address == ADDR_W'(I - 1))) begin
                  r_state <= DONE;
               end else if (r_drain_cnt == DCNT_W'(DRAIN_TIMEOUT - 1)) begin
                  r_state       <= IDLE;
                  r_err_timeout <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 1'b1;
               end
            end
            DONE: begin
               r_state        <= IDLE;
               r_result_ready <= 1'b1;
               r_result_bank  <= w_wr_bank;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Forward T results into the current write bank; T writes outside FEED/DRAIN are dropped.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_res_we   <= 1'b0;
         r_res_addr <= '0;
         for (int unsigned n = 0; n < NU_VALUES; n++) begin
            r_res_data[n] <= '0;
         end
      end else begin
         r_res_we <= w_fwd_active && t_output_valid;
         if (w_fwd_active && t_output_valid) begin
            r_res_addr <= {w_wr_bank, t_output_address};
            for (int unsigned n = 0; n < NU_VALUES; n++) begin
               r_res_data[n] <= w_t_out[n];
            end
         end
      end
   end

   assign frame_ack    = r_frame_ack;
   assign bin_addr     = r_bin_addr;
   assign t_fft_valid  = r_fft_valid;
   assign t_fft_data   = bin_data;
   assign res_we       = r_res_we;
   assign res_addr     = r_res_addr;
   assign res_data_0   = r_res_data[0];
   assign res_data_1   = r_res_data[1];
   assign res_data_2   = r_res_data[2];
   assign bank_full    = w_bank_full;
   assign result_ready = r_result_ready;
   assign result_bank  = r_result_bank;
   assign err_timeout  = r_err_timeout;

endmodule

// File: doc/t_frame_sequencer.md
# t_frame_sequencer

Controller that sequences one FFT frame at a time through the T accumulator datapath. It reads I bins from the FFT bin BRAM and streams them into the T block as one contiguous valid burst. It then forwards T's three result streams into a ping-pong result BRAM and hands each completed bank to the downstream consumer with a full/release handshake. It sits between the FFT bin buffer and the T-result consumer.

## Interface
- BIT_WIDTH, 32, width of bin data and of each T result
- I, 160, bins per frame
- DRAIN_TIMEOUT, 8, cycles allowed after the last bin for the final T write to appear
- ADDR_W (localparam), $clog2(I)

- clk_in  in  1  sole clock
- rst_in  in  1  asynchronous, active-high reset
- frame_ready  in  1  bin buffer holds a complete frame; level
- frame_ack  out  1  one-cycle pulse; frame consumed
- bin_addr  out  ADDR_W  bin BRAM read address; 1-cycle read latency
- bin_data  in  BIT_WIDTH  bin BRAM read data
- t_fft_valid  out  1  to T fft_valid
- t_fft_data  out  BIT_WIDTH  to T fft_data; combinational pass-through of bin_data
- t_output_valid  in  1  from T
- t_output_address  in  ADDR_W  from T
- t_out_0, t_out_1, t_out_2  in  BIT_WIDTH each  T results for nu = 0, 1, 2
- res_we  out  1  result BRAM write enable
- res_addr  out  ADDR_W+1  {bank, index}
- res_data_0, res_data_1, res_data_2  out  BIT_WIDTH each  result write data
- bank_full  out  2  per-bank full flags
- bank_release  in  2  per-bank release pulses from the consumer
- result_ready  out  1  one-cycle pulse when a bank is filled
- result_bank  out  1  bank just filled; valid with result_ready
- err_timeout  out  1  sticky drain-timeout flag

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE → FEED when frame_ready=1 and bank_full[wr_bank]=0. Otherwise the FSM stays in IDLE.
- FEED: issue bin_addr = 0..I-1, one per cycle.
  - t_fft_valid is the registered issue-valid, so it aligns with bin_data.
  - frame_ack pulses in the cycle bin_addr = I-1 is issued.
  - The FSM moves to DRAIN on the following cycle.
- DRAIN: t_fft_valid=0. A drain counter starts at 0 and increments each cycle.
  - A write with t_output_address = I-1 moves the FSM to DONE.
  - Counter reaching DRAIN_TIMEOUT first sets err_timeout. The FSM returns to IDLE with no bank change and no result_ready.
- DONE (1 cycle): set bank_full[wr_bank], pulse result_ready with result_bank = wr_bank, toggle wr_bank, go to IDLE.
- Write forwarding, active in FEED and DRAIN only:
  - res_we <= t_output_valid
  - res_addr <= {wr_bank, t_output_address}
  - res_data_n <= t_out_n
  - t_output_valid in IDLE/DONE is dropped.
- Release: bank_release[b] clears bank_full[b]. Release of a non-full bank is ignored. If release and the DONE set hit the same bank in the same cycle, the set wins.
- The FSM never starts FEED into a full bank. Both banks full means it stalls in IDLE and frame_ready is not acknowledged.
- frame_ready dropping mid-FEED is ignored; the frame completes.
- Reset (any state, async):
  - state=IDLE, wr_bank=0.
  - All outputs 0, including bank_full=2'b00 and err_timeout=0.
  - T clears itself because t_fft_valid falls.

## Timing
- t_fft_valid high for exactly I consecutive cycles per frame.
- The FEED→DRAIN→IDLE→FEED path guarantees at least 2 low cycles between bursts, which T requires to zero its running sums.
- T latency is 3 cycles from t_fft_valid to t_output_valid. The last T write arrives on DRAIN cycle 3.
- res_we lags t_output_valid by 1 cycle.
- Best-case frame period: 1 (IDLE) + I (FEED) + 4 (DRAIN) + 1 (DONE) = I+6 cycles.
- result_ready follows the res_we of index I-1 by exactly 1 cycle.

## Structure
- Package t_seq_pkg holds:
  - the state enum (IDLE, FEED, DRAIN, DONE)
  - NU_VALUES = 3
  - the default DRAIN_TIMEOUT constant
- One sub-module, t_bank_tracker, owns bank_full, the set/release priority and wr_bank. The FSM, address counter and write forwarding live in the top.

## Test plan
- Single frame, bin_data = index+1, T model with 3-cycle latency:
  - exactly 160 t_fft_valid cycles
  - frame_ack when bin_addr=159
  - res_addr 0..159 written in bank 0
  - result_ready with result_bank=0
  - bank_full=01
- Back-to-back frames, consumer never releases:
  - frame 2 goes to bank 1, bank_full=11
  - frame 3 stalls in IDLE with frame_ack low until bank_release=01, then writes bank 0.
- Release and set of bank 1 in the same cycle: bank_full[1] ends 1.
- T model never produces address 159: err_timeout=1 after 8 DRAIN cycles, no result_ready, wr_bank unchanged, next frame reuses the same bank.
- rst_in asserted at bin_addr=80:
  - all outputs 0 immediately (asynchronous), bank_full=00
  - next frame_ready restarts at bin_addr=0 into bank 0.
- Inter-frame gap check: t_fft_valid low ≥2 cycles between every pair of bursts across 4 consecutive frames.
